// File: rtl/simplez_cpu_pkg.sv
// Shared Simplez definitions: opcode field widths, opcode and extended-opcode values, core states.
package simplez_cpu_pkg;

  localparam int unsigned CO_W  = 3;
  localparam int unsigned COE_W = 4;

  typedef enum logic [CO_W-1:0] {
    OP_ST  = 3'd0,
    OP_LD  = 3'd1,
    OP_ADD = 3'd2,
    OP_BR  = 3'd3,
    OP_BZ  = 3'd4,
    OP_CLR = 3'd5,
    OP_DEC = 3'd6,
    OP_EXT = 3'd7
  } opcode_e;

  localparam logic [COE_W-1:0] COE_HALT = 4'hE;
  localparam logic [COE_W-1:0] COE_WAIT = 4'hF;

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_TIMER,
    S_HALTED
  } state_e;

endpackage

// File: rtl/simplez_wait_timer.sv
// Count-down timer behind the WAIT instruction: load CYCLES-1, decrement while running.
module simplez_wait_timer #(
  parameter int unsigned CYCLES = 2400000
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic run,
  output logic zero_c
);

  localparam int unsigned TW = $clog2(CYCLES + 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= TW'(CYCLES - 1);
    end else if (run && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/simplez_cpu.sv
// Simplez core on a req/ack memory/IO bus, with HALT/resume and a cycle-count WAIT.
module simplez_cpu
  import simplez_cpu_pkg::*;
#(
  parameter int unsigned DW          = 12,
  parameter int unsigned AW          = 9,
  parameter int unsigned WAIT_CYCLES = 2400000,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic          clk,
  input  logic          rstn,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  input  logic          resume,
  output logic [DW-1:0] acc,
  output logic          halted,
  output logic [AW-1:0] pc
);

  state_e         state;
  logic [AW-1:0]  cp;
  logic [DW-1:0]  ri;
  logic [DW-1:0]  a;
  logic           z;

  opcode_e        co;
  logic [COE_W-1:0] coe;
  logic [AW-1:0]  cd;
  logic [AW-1:0]  cp_inc;
  logic [DW-1:0]  a_dec;
  logic [DW-1:0]  a_sum;
  logic           timer_load;
  logic           timer_zero;

  assign co     = opcode_e'(ri[DW-1 -: CO_W]);
  assign coe    = ri[DW-1 -: COE_W];
  assign cd     = ri[AW-1:0];
  assign cp_inc = cp + AW'(1);
  assign a_dec  = a - DW'(1);
  assign a_sum  = a + bus_rdata;

  // Bus controls decode straight from registered state so they hold steady until ack.
  assign bus_req   = (state == S_FETCH) || (state == S_MEM);
  assign bus_we    = (state == S_MEM) && (co == OP_ST);
  assign bus_addr  = (state == S_MEM) ? cd : cp;
  assign bus_wdata = a;
  assign acc       = a;
  assign pc        = cp;

  assign timer_load = (state == S_DECODE) && (co == OP_EXT) && (coe == COE_WAIT);

  simplez_wait_timer #(
    .CYCLES(WAIT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rstn   (rstn),
    .load   (timer_load),
    .run    (state == S_TIMER),
    .zero_c (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= S_START;
      cp     <= AW'(RESET_PC);
      ri     <= '0;
      a      <= '0;
      z      <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_START: state <= S_FETCH;

        S_FETCH: begin
          if (bus_ack) begin
            ri    <= bus_rdata;
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (co)
            OP_ST, OP_LD, OP_ADD: state <= S_MEM;
            OP_BR: begin
              cp    <= cd;
              state <= S_FETCH;
            end
            OP_BZ: begin
              cp    <= z ? cd : cp_inc;
              state <= S_FETCH;
            end
            OP_CLR: begin
              a     <= '0;
              z     <= 1'b1;
              cp    <= cp_inc;
              state <= S_FETCH;
            end
            OP_DEC: begin
              a     <= a_dec;
              z     <= (a_dec == '0);
              cp    <= cp_inc;
              state <= S_FETCH;
            end
            OP_EXT: begin
              if (coe == COE_HALT) begin
                halted <= 1'b1;
                state  <= S_HALTED;
              end else begin
                state  <= S_TIMER;
              end
            end
          endcase
        end

        // Operand access; ST leaves A and Z untouched.
        S_MEM: begin
          if (bus_ack) begin
            case (co)
              OP_LD: begin
                a <= bus_rdata;
                z <= (bus_rdata == '0);
              end
              OP_ADD: begin
                a <= a_sum;
                z <= (a_sum == '0);
              end
              default: ;
            endcase
            cp    <= cp_inc;
            state <= S_FETCH;
          end
        end

        S_TIMER: begin
          if (timer_zero) begin
            cp    <= cp_inc;
            state <= S_FETCH;
          end
        end

        S_HALTED: begin
          if (resume) begin
            halted <= 1'b0;
            cp     <= cp_inc;
            state  <= S_FETCH;
          end
        end

        default: state <= S_START;
      endcase
    end
  end

endmodule

// File: tb/tb_simplez_cpu.sv
// Bench for simplez_cpu: bus responder with wait states, transaction monitor, ISA-level reference model.
module tb_simplez_cpu;

  localparam int unsigned DW  = 12;
  localparam int unsigned AW  = 9;
  localparam int unsigned WC  = 10;
  localparam int unsigned RPC = 0;
  localparam int          RD  = 3;
  localparam int          MSZ = 1 << AW;

  typedef struct packed {
    int unsigned   cyc;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } txn_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          bus_req, bus_we, bus_ack, resume, halted;
  logic [AW-1:0] bus_addr, pc;
  logic [DW-1:0] bus_wdata, bus_rdata, acc;

  logic          ack_m = 1'b0;
  logic          ack_force = 1'b0;
  logic [DW-1:0] rdata_m = '0;
  logic [DW-1:0] rdata_force = '0;

  assign bus_ack   = ack_m | ack_force;
  assign bus_rdata = ack_force ? rdata_force : rdata_m;

  always #5 clk = ~clk;

  simplez_cpu #(
    .DW(DW), .AW(AW), .WAIT_CYCLES(WC), .RESET_PC(RPC)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .resume    (resume),
    .acc       (acc),
    .halted    (halted),
    .pc        (pc)
  );

  logic [DW-1:0] mem     [0:MSZ-1];
  logic [DW-1:0] mdl_mem [0:MSZ-1];
  txn_t          obs_q[$], exp_q[$];
  int            halt_obs[$], halt_exp[$];
  logic [DW-1:0] exp_acc;
  logic [AW-1:0] exp_pc;

  int  n_chk = 0, n_fail = 0;
  int  cyc = 0;
  int  ws = 0, wcnt = 0, res_max = 0, res_used = 0, res_at = -1;
  bit  ack_en = 1'b0, no_ack_write = 1'b0, noise = 1'b0;
  bit  in_txn = 1'b0, halted_q = 1'b0, drop_chk = 1'b0;
  logic [AW-1:0] h_addr;
  logic          h_we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ins(input int op, input int cd);
    return {3'(op), AW'(cd)};
  endfunction

  always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

  // Bus responder, transaction monitor and resume driver.
  always @(negedge clk) begin
    resume = 1'b0;
    if (!rstn) begin
      ack_m = 1'b0; in_txn = 1'b0; res_at = -1; res_used = 0;
      drop_chk = 1'b0; halted_q = 1'b0;
      obs_q.delete(); halt_obs.delete();
    end else begin
      if (drop_chk) begin
        check("halted_drop", 32'(halted), 32'd0);
        drop_chk = 1'b0;
      end
      if (ack_m) begin
        ack_m = 1'b0;
        in_txn = 1'b0;
      end
      if (!bus_req) begin
        in_txn = 1'b0;
      end else begin
        if (!in_txn) begin
          in_txn = 1'b1; wcnt = 0; h_addr = bus_addr; h_we = bus_we;
          obs_q.push_back('{cyc: 32'(cyc), addr: bus_addr, we: bus_we,
                            wdata: bus_we ? bus_wdata : '0});
        end else begin
          check("addr_stable", 32'(bus_addr), 32'(h_addr));
          check("we_stable", 32'(bus_we), 32'(h_we));
        end
        if (ack_en && !(no_ack_write && bus_we)) begin
          if (wcnt >= ws) begin
            ack_m = 1'b1;
            rdata_m = mem[bus_addr];
            if (bus_we) mem[bus_addr] = bus_wdata;
          end else begin
            wcnt++;
          end
        end
      end
      if (halted && !halted_q) begin
        halt_obs.push_back(cyc);
        if (res_used < res_max) begin
          res_at = cyc + RD;
          res_used++;
        end
      end
      halted_q = halted;
      if (res_at >= 0 && cyc == res_at) begin
        resume = 1'b1; drop_chk = 1'b1; res_at = -1;
      end else if (noise && !halted && $urandom_range(0, 3) == 0) begin
        resume = 1'b1;
      end
    end
  end

  // Instruction-level interpreter: expected bus transactions, their start cycles and halt cycles.
  task automatic run_model(input int ws_m, input int n_res);
    int            t = 1;
    int            res = n_res;
    logic [AW-1:0] p = AW'(RPC);
    logic [AW-1:0] cd;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] iw;
    bit            z = 1'b0;
    exp_q.delete(); halt_exp.delete();
    for (int steps = 0; steps < 1000; steps++) begin
      exp_q.push_back('{cyc: 32'(t), addr: p, we: 1'b0, wdata: '0});
      iw = mdl_mem[p];
      cd = iw[AW-1:0];
      t += 2 + ws_m;
      case (int'(iw[DW-1 -: 3]))
        0: begin exp_q.push_back('{32'(t), cd, 1'b1, a}); mdl_mem[cd] = a; t += 1 + ws_m; p++; end
        1: begin exp_q.push_back('{32'(t), cd, 1'b0, '0}); a = mdl_mem[cd]; z = (a == '0); t += 1 + ws_m; p++; end
        2: begin exp_q.push_back('{32'(t), cd, 1'b0, '0}); a = a + mdl_mem[cd]; z = (a == '0); t += 1 + ws_m; p++; end
        3: p = cd;
        4: p = z ? cd : p + 1'b1;
        5: begin a = '0; z = 1'b1; p++; end
        6: begin a = a - 1'b1; z = (a == '0); p++; end
        default: begin
          if (iw[DW-4]) begin
            t += WC; p++;
          end else begin
            halt_exp.push_back(t);
            if (res == 0) break;
            res--; t += RD + 1; p++;
          end
        end
      endcase
    end
    exp_acc = a;
    exp_pc  = p;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < MSZ; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic run_prog(input string name, input int ws_i, input int n_res, input bit noise_i);
    int diffs = 0;
    ws = ws_i; res_max = n_res; noise = noise_i;
    ack_en = 1'b1; no_ack_write = 1'b0; ack_force = 1'b0;
    mdl_mem = mem;
    run_model(ws_i, n_res);
    do_reset();
    for (int i = 0; i < 5000 && halt_obs.size() < n_res + 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check({name, " halts"}, 32'(halt_obs.size()), 32'(halt_exp.size()));
    for (int i = 0; i < halt_obs.size() && i < halt_exp.size(); i++)
      check($sformatf("%s halt%0d_cyc", name, i), 32'(halt_obs[i]), 32'(halt_exp[i]));
    check({name, " txn_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s txn%0d_cyc", name, i), obs_q[i].cyc, exp_q[i].cyc);
      check($sformatf("%s txn%0d_addr", name, i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
      check($sformatf("%s txn%0d_we", name, i), 32'(obs_q[i].we), 32'(exp_q[i].we));
      check($sformatf("%s txn%0d_wdata", name, i), 32'(obs_q[i].wdata), 32'(exp_q[i].wdata));
    end
    for (int i = 0; i < MSZ; i++) if (mem[i] !== mdl_mem[i]) diffs++;
    check({name, " mem_diffs"}, 32'(diffs), 32'd0);
    check({name, " acc"}, 32'(acc), 32'(exp_acc));
    check({name, " pc"}, 32'(pc), 32'(exp_pc));
    check({name, " halted"}, 32'(halted), 32'd1);
  endtask

  task automatic load_basic();
    clear_mem();
    mem[0] = ins(1, 'h10); mem[1] = ins(2, 'h11); mem[2] = ins(0, 'h12); mem[3] = 12'hE00;
    mem['h10] = 12'd5; mem['h11] = 12'd7;
  endtask

  initial begin
    resume = 1'b0;

    // Reset values
    @(negedge clk); @(negedge clk);
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst acc", 32'(acc), 32'd0);
    check("rst pc", 32'(pc), 32'(RPC));
    check("rst halted", 32'(halted), 32'd0);

    // LD/ADD/ST/HALT, zero-wait then three wait states
    load_basic();
    run_prog("basic_ws0", 0, 0, 1'b0);
    check("basic halt_cycle", 32'(halt_obs.size() > 0 ? halt_obs[0] : -1), 32'd12);
    check("basic mem12", 32'(mem['h12]), 32'd12);
    check("basic acc12", 32'(acc), 32'd12);
    load_basic();
    run_prog("basic_ws3", 3, 0, 1'b1);
    check("basic_ws3 mem12", 32'(mem['h12]), 32'd12);
    check("basic_ws3 acc12", 32'(acc), 32'd12);

    // CLR; BZ taken, then DEC from 0 and BZ not taken
    clear_mem();
    mem[0] = ins(5, 0); mem[1] = ins(4, 5); mem[5] = ins(6, 0); mem[6] = ins(4, 5); mem[7] = 12'hE00;
    run_prog("bz", $urandom_range(0, 2), 0, 1'b1);
    if (obs_q.size() > 4) begin
      check("bz taken_addr", 32'(obs_q[2].addr), 32'h5);
      check("bz fall_addr", 32'(obs_q[4].addr), 32'h7);
    end
    check("bz dec_wrap", 32'(acc), 32'hFFF);

    // ADD overflow to zero, BZ on it, cp wrap 0x1FF -> 0x000 into a patched HALT
    clear_mem();
    mem[0] = ins(3, 'h1FA);
    mem['h1FA] = ins(1, 'h20); mem['h1FB] = ins(0, 0); mem['h1FC] = ins(1, 'h21);
    mem['h1FD] = ins(2, 'h22); mem['h1FE] = ins(4, 'h40); mem['h40] = ins(3, 'h1FF);
    mem['h1FF] = ins(6, 0);
    mem['h20] = 12'hE00; mem['h21] = 12'hFFF; mem['h22] = 12'd1;
    run_prog("wrap", 0, 0, 1'b0);
    check("wrap pc0", 32'(pc), 32'h0);
    check("wrap acc", 32'(acc), 32'hFFF);

    // WAIT timing, HALT then resume
    clear_mem();
    mem[0] = 12'hF00; mem[1] = 12'hE00; mem[2] = ins(5, 0); mem[3] = 12'hE00;
    run_prog("wait", 0, 1, 1'b1);
    if (obs_q.size() > 2) begin
      check("wait next_fetch_cyc", obs_q[1].cyc, 32'd13);
      check("wait next_fetch_addr", 32'(obs_q[1].addr), 32'h1);
      check("resume fetch_addr", 32'(obs_q[2].addr), 32'h2);
    end

    // Reset during a withheld MEM write; ack during START must be ignored
    clear_mem();
    mem[0] = ins(1, 'h10); mem[1] = ins(0, 'h12); mem[2] = 12'hE00; mem['h10] = 12'd5;
    ws = 0; res_max = 0; noise = 1'b0; ack_en = 1'b1; no_ack_write = 1'b1;
    do_reset();
    for (int i = 0; i < 50 && !(bus_req && bus_we); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("rstw req_held", 32'(bus_req && bus_we), 32'd1);
    check("rstw acc_before", 32'(acc), 32'd5);
    rstn = 1'b0;
    @(negedge clk);
    check("rstw bus_req", 32'(bus_req), 32'd0);
    check("rstw acc", 32'(acc), 32'd0);
    check("rstw pc", 32'(pc), 32'(RPC));
    ack_en = 1'b0; no_ack_write = 1'b0;
    ack_force = 1'b1; rdata_force = 12'hE00; rstn = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    check("rstw fetch_req", 32'(bus_req), 32'd1);
    check("rstw fetch_addr", 32'(bus_addr), 32'(RPC));
    ack_en = 1'b1;
    for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
    check("rstw final_acc", 32'(acc), 32'd5);
    check("rstw mem12", 32'(mem['h12]), 32'd5);

    // Random straight-line programs with forward branches
    for (int r = 0; r < 20; r++) begin
      clear_mem();
      for (int i = 0; i < 31; i++) begin
        int op = $urandom_range(0, 7);
        if (op == 7)      mem[i] = 12'hF00;
        else if (op <= 2) mem[i] = ins(op, 'h100 + $urandom_range(0, 15));
        else if (op <= 4) mem[i] = ins(op, $urandom_range(31, i + 1));
        else              mem[i] = ins(op, $urandom_range(0, MSZ - 1));
      end
      mem[31] = 12'hE00;
      for (int i = 'h100; i < 'h110; i++) begin
        case ($urandom_range(0, 3))
          0: mem[i] = '0;
          1: mem[i] = 12'hFFF;
          default: mem[i] = DW'($urandom);
        endcase
      end
      run_prog($sformatf("rnd%0d", r), $urandom_range(0, 3), 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
